// File: rtl/tt_lut_pkg.sv
// Shared types and helpers for the truth-table evaluator: FSM states, MSB-first lookup, N_IN bounds.
package tt_lut_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned N_IN_MIN = 1;
  localparam int unsigned N_IN_MAX = 6;

  function automatic bit n_in_ok(input int unsigned n);
    return (n >= N_IN_MIN) && (n <= N_IN_MAX);
  endfunction

  // Row 0 lives in the table MSB, so index k reads bit (tt_w-1-k).
  function automatic logic tt_lookup(input logic [63:0] tt, input int unsigned tt_w,
                                     input int unsigned idx);
    logic [5:0] pos;
    pos = 6'(tt_w - 32'd1 - idx);
    return tt[pos];
  endfunction

endpackage

// File: rtl/tt_lut_out_reg.sv
// One-entry valid/ready register, 1-cycle latency, full throughput.
// Accepts when empty or when the held entry drains the same cycle; data holds while stalled.
module tt_lut_out_reg #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/tt_lut_engine.sv
// Run-time programmable N-input truth-table evaluator with exhaustive self-sweep.
// Result 1 cycle after accept; in_ready follows the output register's load enable.
module tt_lut_engine
  import tt_lut_pkg::*;
#(
  parameter int                  N_IN       = 3,
  parameter logic [2**N_IN-1:0]  TT_DEFAULT = 8'h9D
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_load_i,
  input  logic [2**N_IN-1:0]  cfg_tt_i,
  output logic                cfg_err_o,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [N_IN-1:0]     in_vec_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_bit_o,
  output logic [N_IN-1:0]     out_vec_o,
  input  logic                sweep_start_i,
  output logic                sweep_busy_o,
  output logic                sweep_done_o
);

  localparam int TT_W  = 2**N_IN;
  localparam int CNT_W = $clog2(TT_W) + 1;

  if (!n_in_ok(N_IN)) begin : g_bad_n_in
    $error("tt_lut_engine: N_IN must be in 1..6");
  end

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TT_W-1:0]   tt_q;
  logic              cfg_err_q;

  logic              stage_in_vld;
  logic              stage_rdy;
  logic [N_IN-1:0]   vec_sel;
  logic [N_IN:0]     stage_in_dat;
  logic [N_IN:0]     stage_out_dat;

  assign vec_sel      = (state_q == IDLE) ? in_vec_i : cnt_q[N_IN-1:0];
  assign stage_in_dat = {tt_lookup(64'(tt_q), TT_W, 32'(vec_sel)), vec_sel};
  assign stage_in_vld = (state_q == IDLE) ? in_valid_i : (state_q == SWEEP);

  assign in_ready_o   = (state_q == IDLE) && stage_rdy;
  assign sweep_busy_o = (state_q != IDLE);
  assign sweep_done_o = (state_q == DRAIN) && out_valid_o && out_ready_i;
  assign cfg_err_o    = cfg_err_q;
  assign out_bit_o    = stage_out_dat[N_IN];
  assign out_vec_o    = stage_out_dat[N_IN-1:0];

  tt_lut_out_reg #(.W(N_IN + 1)) u_out_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (stage_in_vld),
    .in_ready_o (stage_rdy),
    .in_data_i  (stage_in_dat),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (stage_out_dat)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tt_q      <= TT_DEFAULT;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_load_i && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (cfg_load_i) tt_q <= cfg_tt_i;
          if (sweep_start_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          if (stage_rdy) begin
            // Last row goes out: counter parks at 0 and is not reused in DRAIN.
            if (cnt_q == CNT_W'(TT_W - 1)) begin
              state_q <= DRAIN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_valid_o && out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_lut_engine.sv
// Directed bench for tt_lut_engine: streaming, backpressure, reprogramming, sweep, reset abort.
module tb_tt_lut_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [7:0] cfg_tt;
  logic       cfg_err;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic [2:0] out_vec;
  logic       sweep_start;
  logic       sweep_busy;
  logic       sweep_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tt_lut_engine #(.N_IN(3), .TT_DEFAULT(8'h9D)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_load_i   (cfg_load),
    .cfg_tt_i     (cfg_tt),
    .cfg_err_o    (cfg_err),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_vec_i     (in_vec),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_bit_o    (out_bit),
    .out_vec_o    (out_vec),
    .sweep_start_i(sweep_start),
    .sweep_busy_o (sweep_busy),
    .sweep_done_o (sweep_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bits per row, row 0 first.
  logic [7:0] exp_9d;
  logic [7:0] exp_6b;

  initial begin
    exp_9d = 8'b1001_1101;  // rows 0..7 -> 1,0,0,1,1,1,0,1 read MSB-first
    exp_6b = 8'b0110_1011;  // rows 0..7 -> 0,1,1,0,1,0,1,1

    rst = 1'b1; cfg_load = 1'b0; cfg_tt = 8'h00; in_valid = 1'b0; in_vec = 3'd0;
    out_ready = 1'b1; sweep_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_out_bit", 8'(out_bit), 8'd0);
    chk("rst_out_vec", 8'(out_vec), 8'd0);
    chk("rst_cfg_err", 8'(cfg_err), 8'd0);
    chk("rst_busy", 8'(sweep_busy), 8'd0);
    chk("rst_done", 8'(sweep_done), 8'd0);
    rst = 1'b0;
    tick();

    // 1: stream every row through the default table.
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_vec = 3'(k);
      #1;
      chk("t1_in_ready", 8'(in_ready), 8'd1);
      tick();
      chk("t1_valid", 8'(out_valid), 8'd1);
      chk("t1_vec", 8'(out_vec), 8'(k));
      chk("t1_bit", 8'(out_bit), 8'(exp_9d[7-k]));
    end
    in_valid = 1'b0;
    tick();
    chk("t1_empty", 8'(out_valid), 8'd0);

    // 2: backpressure holds the result and blocks the next input.
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 3'd3;
    #1;
    chk("t2_rdy_empty", 8'(in_ready), 8'd1);
    tick();
    in_vec = 3'd6;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t2_rdy_stall", 8'(in_ready), 8'd0);
      chk("t2_hold_vec", 8'(out_vec), 8'd3);
      chk("t2_hold_bit", 8'(out_bit), 8'd1);
      chk("t2_hold_vld", 8'(out_valid), 8'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t2_rdy_release", 8'(in_ready), 8'd1);
    tick();
    chk("t2_next_vec", 8'(out_vec), 8'd6);
    chk("t2_next_bit", 8'(out_bit), 8'd0);
    in_valid = 1'b0;
    tick();
    chk("t2_empty", 8'(out_valid), 8'd0);

    // 3: reprogram; the input accepted with the load sees the old table.
    cfg_load = 1'b1; cfg_tt = 8'h01; in_valid = 1'b1; in_vec = 3'd0;
    tick();
    chk("t3_old_tbl_bit", 8'(out_bit), 8'd1);
    chk("t3_old_tbl_vec", 8'(out_vec), 8'd0);
    chk("t3_no_err", 8'(cfg_err), 8'd0);
    cfg_load = 1'b0; in_vec = 3'd7;
    tick();
    chk("t3_new_111", 8'(out_bit), 8'd1);
    in_vec = 3'd0;
    tick();
    chk("t3_new_000", 8'(out_bit), 8'd0);
    in_valid = 1'b0;
    tick();

    // 4+5: load and sweep start together; the sweep must use the new table.
    cfg_load = 1'b1; cfg_tt = 8'h6B; sweep_start = 1'b1;
    tick();
    chk("t4_busy", 8'(sweep_busy), 8'd1);
    chk("t4_no_out_yet", 8'(out_valid), 8'd0);
    cfg_tt = 8'hFF; in_valid = 1'b1; in_vec = 3'd7;
    #1;
    chk("t5_in_ready_0", 8'(in_ready), 8'd0);
    tick();
    cfg_load = 1'b0; sweep_start = 1'b0;
    chk("t5_cfg_err", 8'(cfg_err), 8'd1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      if (k == 1) chk("t5_cfg_err_pulse", 8'(cfg_err), 8'd0);
      chk("t4_valid", 8'(out_valid), 8'd1);
      chk("t4_vec", 8'(out_vec), 8'(k));
      chk("t4_bit", 8'(out_bit), 8'(exp_6b[7-k]));
      chk("t4_done", 8'(sweep_done), (k == 7) ? 8'd1 : 8'd0);
      chk("t4_busy_in", 8'(sweep_busy), 8'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("t4_busy_fall", 8'(sweep_busy), 8'd0);
    chk("t4_done_fall", 8'(sweep_done), 8'd0);
    chk("t5_in_ignored", 8'(out_valid), 8'd0);
    in_valid = 1'b1; in_vec = 3'd0;
    tick();
    chk("t5_tbl_kept", 8'(out_bit), 8'd0);
    in_valid = 1'b0;
    tick();

    // 6: reset at sweep index 4 aborts and restores the default table.
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (5) tick();
    chk("t6_at_idx4", 8'(out_vec), 8'd4);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 8'(out_valid), 8'd0);
    chk("t6_rst_vec", 8'(out_vec), 8'd0);
    chk("t6_rst_bit", 8'(out_bit), 8'd0);
    chk("t6_rst_busy", 8'(sweep_busy), 8'd0);
    chk("t6_rst_done", 8'(sweep_done), 8'd0);
    #1;
    rst = 1'b0;
    tick();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    chk("t6_restart_vec0", 8'(out_vec), 8'd0);
    chk("t6_default_bit0", 8'(out_bit), 8'(exp_9d[7]));
    tick();
    chk("t6_restart_vec1", 8'(out_vec), 8'd1);
    chk("t6_default_bit1", 8'(out_bit), 8'(exp_9d[6]));
    repeat (8) tick();
    chk("t6_sweep_ends", 8'(sweep_busy), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
